// File: rtl/bufgce_div_array_pkg.sv
// bufgce_div_array_pkg: shared state encoding, CE_TYPE codes and stats width for the clock-enable divider array
package bufgce_div_array_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;
  localparam int CE_TYPE_SYNC = 0;
  localparam int CE_TYPE_ASYNC = 1;
  localparam int STATS_W = 16;
endpackage

// File: rtl/bufgce_div_chan.sv
// bufgce_div_chan: one channel (CE sync chain, IDLE/RUN/DRAIN FSM, divide counter); BUFGCE_DIV_ARRAY_STATS_EN adds a tick counter
module bufgce_div_chan
  import bufgce_div_array_pkg::*;
#(
  parameter int DIV_W = 3,
  parameter int CE_MODE = CE_TYPE_SYNC,
  parameter int SYNC_STAGES = 2,
  parameter bit CE_INV = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             active,
  output logic             drain
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
  , output logic [STATS_W-1:0] tick_cnt
`endif
);
  state_t st, st_n;
  logic [DIV_W-1:0] cnt, cnt_n, div_q, div_n;
  logic tick_n, ce_i, ce_s, zero;
  assign ce_i = ce ^ CE_INV;
  if (CE_MODE == CE_TYPE_SYNC) begin : g_sync
    logic [SYNC_STAGES-1:0] sr;
    always_ff @(posedge clk) sr <= rst ? '0 : {sr[SYNC_STAGES-2:0], ce_i};
    assign ce_s = sr[SYNC_STAGES-1];
  end else begin : g_async
    assign ce_s = ce_i;
  end
  assign zero = cnt == '0;
  assign active = st != ST_IDLE;
  assign drain = st == ST_DRAIN;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    div_n = div_q;
    tick_n = 1'b0;
    unique case (st)
      ST_IDLE: if (ce_s) begin
        st_n = ST_RUN;
        div_n = div;
        cnt_n = div;
      end
      ST_RUN: if (!ce_s && CE_MODE == CE_TYPE_ASYNC) begin
        st_n = ST_IDLE;
        cnt_n = '0;
      end else begin
        tick_n = zero;
        cnt_n = zero ? div_q : cnt - 1'b1;
        st_n = ce_s ? ST_RUN : ST_DRAIN;
      end
      ST_DRAIN: begin
        // re-raise during drain resumes the same period; final tick without re-raise ends the channel
        tick_n = zero;
        cnt_n = zero ? div_q : cnt - 1'b1;
        st_n = ce_s ? ST_RUN : (zero ? ST_IDLE : ST_DRAIN);
      end
      default: st_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
      cnt <= '0;
      div_q <= '0;
      tick <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      div_q <= div_n;
      tick <= tick_n;
    end
  end
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) tick_cnt <= '0;
    else if (tick && tick_cnt != '1) tick_cnt <= tick_cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/bufgce_div_array.sv
// bufgce_div_array: NUM_CH independent clock-enable/divide channels on one clock
// BUFGCE_DIV_ARRAY_STATS_EN adds O_TICK_CNT (16-bit saturating tick count per channel)
module bufgce_div_array
  import bufgce_div_array_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 3,
  parameter string CE_TYPE = "SYNC",
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] IS_CE_INVERTED = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       CE,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  output logic [NUM_CH-1:0]       O_TICK,
  output logic [NUM_CH-1:0]       O_ACTIVE,
  output logic [NUM_CH-1:0]       O_DRAIN
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
  , output logic [NUM_CH*STATS_W-1:0] O_TICK_CNT
`endif
);
  localparam int CE_MODE = (CE_TYPE == "ASYNC") ? CE_TYPE_ASYNC : CE_TYPE_SYNC;
  if (CE_TYPE != "SYNC" && CE_TYPE != "ASYNC") begin : g_bad_type
    $error("bufgce_div_array: CE_TYPE must be SYNC or ASYNC");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("bufgce_div_array: SYNC_STAGES must be 2..4");
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    bufgce_div_chan #(
      .DIV_W(DIV_W),
      .CE_MODE(CE_MODE),
      .SYNC_STAGES(SYNC_STAGES),
      .CE_INV(IS_CE_INVERTED[k])
    ) u_chan (
      .clk(CLK),
      .rst(RST),
      .ce(CE[k]),
      .div(DIV[k*DIV_W +: DIV_W]),
      .tick(O_TICK[k]),
      .active(O_ACTIVE[k]),
      .drain(O_DRAIN[k])
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
      , .tick_cnt(O_TICK_CNT[k*STATS_W +: STATS_W])
`endif
    );
  end
endmodule

// File: tb/tb_bufgce_div_array.sv
// tb_bufgce_div_array: random CE/DIV/RST stimulus on a SYNC and an ASYNC (inverted CE) array vs a tick-schedule model
module tb_bufgce_div_array;
  localparam int N = 4;
  localparam int W = 3;
  localparam int S = 2;
  localparam logic [N-1:0] INV1 = 4'b0101;
  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0] CE;
  logic [N*W-1:0] DIV;
  logic [N-1:0] t0, a0, d0, t1, a1, d1;
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
  logic [N*16-1:0] c0, c1;
`endif
  always #5 CLK = ~CLK;
  bufgce_div_array #(.NUM_CH(N), .DIV_W(W), .CE_TYPE("SYNC"), .SYNC_STAGES(S), .IS_CE_INVERTED(4'b0000)) u_sync (
    .CLK(CLK), .RST(RST), .CE(CE), .DIV(DIV), .O_TICK(t0), .O_ACTIVE(a0), .O_DRAIN(d0)
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
    , .O_TICK_CNT(c0)
`endif
  );
  bufgce_div_array #(.NUM_CH(N), .DIV_W(W), .CE_TYPE("ASYNC"), .SYNC_STAGES(S), .IS_CE_INVERTED(INV1)) u_async (
    .CLK(CLK), .RST(RST), .CE(CE), .DIV(DIV), .O_TICK(t1), .O_ACTIVE(a1), .O_DRAIN(d1)
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
    , .O_TICK_CNT(c1)
`endif
  );
  int errs = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // model: each running channel owns an absolute tick schedule (next tick edge, period div+1)
  bit m_act[2][N], m_drn[2][N], m_tick[2][N];
  int m_d[2][N], m_cnt[2][N];
  longint m_next[2][N];
  longint n = 0;
  bit dl[N][$];
  task automatic model_step();
    bit cs;
    n++;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) begin
        if (RST) begin
          m_act[i][k] = 0; m_drn[i][k] = 0; m_tick[i][k] = 0; m_cnt[i][k] = 0;
          continue;
        end
        if (m_tick[i][k] && m_cnt[i][k] < 65535) m_cnt[i][k]++;
        cs = (i == 0) ? dl[k][0] : (CE[k] ^ INV1[k]);
        m_tick[i][k] = 0;
        if (!m_act[i][k]) begin
          if (cs) begin
            m_act[i][k] = 1;
            m_d[i][k] = int'(DIV[k*W +: W]);
            m_next[i][k] = n + m_d[i][k] + 1;
          end
        end else if (i == 1 && !cs) begin
          m_act[i][k] = 0;
        end else begin
          m_tick[i][k] = (n == m_next[i][k]);
          if (m_tick[i][k]) m_next[i][k] += m_d[i][k] + 1;
          if (m_drn[i][k]) begin
            if (cs) m_drn[i][k] = 0;
            else if (m_tick[i][k]) begin m_act[i][k] = 0; m_drn[i][k] = 0; end
          end else if (!cs) m_drn[i][k] = 1;
        end
      end
    for (int k = 0; k < N; k++) begin
      if (RST) begin
        dl[k].delete();
        repeat (S) dl[k].push_back(1'b0);
      end else begin
        void'(dl[k].pop_front());
        dl[k].push_back(CE[k]);
      end
    end
  endtask
  task automatic compare();
    logic [N-1:0] et, ea, ed;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) begin
        et[k] = m_tick[i][k]; ea[k] = m_act[i][k]; ed[k] = m_drn[i][k];
      end
      check($sformatf("tick%0d", i), 64'(i ? t1 : t0), 64'(et));
      check($sformatf("active%0d", i), 64'(i ? a1 : a0), 64'(ea));
      check($sformatf("drain%0d", i), 64'(i ? d1 : d0), 64'(ed));
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
      for (int k = 0; k < N; k++)
        check($sformatf("tcnt%0d_%0d", i, k), 64'((i ? c1 : c0) >> (16 * k)) & 64'hFFFF, 64'(m_cnt[i][k]));
`endif
    end
  endtask
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare();
  endtask
  initial begin
    for (int k = 0; k < N; k++) repeat (S) dl[k].push_back(1'b0);
    RST = 1'b1;
    CE = '1;
    DIV = N*W'($urandom);
    repeat (3) cycle();
    check("rst_zero", 64'({t0, a0, d0, t1, a1, d1}), 64'd0);
    RST = 1'b0;
    cycle();
    cycle();
    check("lat_before", 64'(a0[0]), 64'd0);
    cycle();
    check("lat_at3", 64'(a0[0]), 64'd1);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(11) == 0) CE[k] = ~CE[k];
        if ($urandom_range(3) == 0) DIV[k*W +: W] = W'($urandom);
      end
      RST = ($urandom_range(399) == 0);
      cycle();
    end
`ifdef BUFGCE_DIV_ARRAY_STATS_EN
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    CE = '1;
    DIV = '0;
    repeat (70000) cycle();
    check("sat_ch0", 64'(c0[15:0]), 64'hFFFF);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
